coin_spawner: RTL and testbench

//  Upstream stage of the coin collision checker: owns the single on-screen coin's position and lifecycle.

---
 rtl/coin_spawner.sv | 159 +++++++++++++++
 tb/tb_coin_spawner.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_spawner.sv
// coin_spawner: owns the single on-screen coin. Scrolls it left on each frame
// Tick, respawns it at the right edge at an LFSR-derived height, hides it and
// counts it when the collision checker reports a hit.
// Optional feature macro: COIN_SPEEDUP_EN (speed grows with coins collected).
module coin_spawner #(
    parameter int SCREEN_RIGHT  = 640,
    parameter int COIN_WIDTH    = 20,
    parameter int COIN_SPEED    = 2,
    parameter int Y_MIN         = 100,
    parameter int RESPAWN_DELAY = 60
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       Start,
    input  logic       Ack,
    input  logic       Tick,
    input  logic       get_Zero,
    output logic [9:0] X_Coin_OO_L,
    output logic [9:0] X_Coin_OO_R,
    output logic [9:0] Y_Coin_00,
    output logic       Coin_Visible,
    output logic       Collect_Pulse,
    output logic [7:0] Coin_Count
);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GONE = 2'd2;

    localparam logic [9:0] X_PARK  = 10'(SCREEN_RIGHT);
    localparam logic [9:0] XR_PARK = 10'(SCREEN_RIGHT + COIN_WIDTH);
    localparam logic [9:0] Y_BASE  = 10'(Y_MIN);
    localparam logic [9:0] WIDTH   = 10'(COIN_WIDTH);

    // Delay counter runs 0..RESPAWN_DELAY-1; the Tick seen at the last value respawns.
    localparam int DW = (RESPAWN_DELAY > 1) ? $clog2(RESPAWN_DELAY) : 1;
    localparam logic [DW-1:0] DLY_LAST = DW'(RESPAWN_DELAY - 1);

    logic [1:0]    state;
    logic [7:0]    lfsr;
    logic          lfsr_fb;
    logic [DW-1:0] delay_cnt;
    logic [9:0]    spawn_y;
    logic [9:0]    speed;
    logic [9:0]    x_moved;
    logic [7:0]    count_inc;
    logic          collect;
    logic          start_load;

    assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign spawn_y    = Y_BASE + {2'b00, lfsr};
    assign x_moved    = X_Coin_OO_L - speed;
    assign count_inc  = (Coin_Count == 8'hFF) ? 8'hFF : Coin_Count + 8'd1;
    assign collect    = !Ack && (state == S_RUN) && get_Zero;
    assign start_load = !Ack && (state == S_INIT) && Start;

`ifdef COIN_SPEEDUP_EN
    logic [9:0] next_speed;

    // Bonus is count/8 capped at 3, taken from the count after this collect.
    assign next_speed = 10'(COIN_SPEED) +
                        ((count_inc >= 8'd24) ? 10'd3 : {8'd0, count_inc[4:3]});

    // Effective speed register: reset each game, refreshed on every collect.
    always_ff @(posedge Clk) begin
        if (!reset || start_load)
            speed <= 10'(COIN_SPEED);
        else if (collect)
            speed <= next_speed;
    end
`else
    assign speed = 10'(COIN_SPEED);
`endif

    // Coin lifecycle FSM, position/visibility outputs, collect counter and LFSR.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            state         <= S_INIT;
            X_Coin_OO_L   <= X_PARK;
            X_Coin_OO_R   <= XR_PARK;
            Y_Coin_00     <= Y_BASE;
            Coin_Visible  <= 1'b0;
            Collect_Pulse <= 1'b0;
            Coin_Count    <= 8'd0;
            lfsr          <= 8'hA5;
            delay_cnt     <= '0;
        end else begin
            lfsr          <= {lfsr[6:0], lfsr_fb};
            Collect_Pulse <= 1'b0;
            if (Ack) begin
                // End of game wins over everything; the count survives until Start.
                state        <= S_INIT;
                X_Coin_OO_L  <= X_PARK;
                X_Coin_OO_R  <= XR_PARK;
                Y_Coin_00    <= Y_BASE;
                Coin_Visible <= 1'b0;
                delay_cnt    <= '0;
            end else begin
                case (state)
                    S_INIT: begin
                        if (Start) begin
                            state        <= S_RUN;
                            Coin_Count   <= 8'd0;
                            X_Coin_OO_L  <= X_PARK;
                            X_Coin_OO_R  <= XR_PARK;
                            Y_Coin_00    <= spawn_y;
                            Coin_Visible <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (get_Zero) begin
                            // Hit beats a simultaneous Tick: count it, park the coin.
                            state         <= S_GONE;
                            Coin_Count    <= count_inc;
                            Collect_Pulse <= 1'b1;
                            X_Coin_OO_L   <= X_PARK;
                            X_Coin_OO_R   <= XR_PARK;
                            Coin_Visible  <= 1'b0;
                            delay_cnt     <= '0;
                        end else if (Tick) begin
                            if (X_Coin_OO_L >= speed) begin
                                X_Coin_OO_L <= x_moved;
                                X_Coin_OO_R <= x_moved + WIDTH;
                            end else if (X_Coin_OO_L != 10'd0) begin
                                // Clamp at the left edge instead of wrapping.
                                X_Coin_OO_L <= 10'd0;
                                X_Coin_OO_R <= WIDTH;
                            end else begin
                                // Already at 0: the coin leaves the screen uncollected.
                                state        <= S_GONE;
                                X_Coin_OO_L  <= X_PARK;
                                X_Coin_OO_R  <= XR_PARK;
                                Coin_Visible <= 1'b0;
                                delay_cnt    <= '0;
                            end
                        end
                    end
                    S_GONE: begin
                        // get_Zero is ignored here so a held hit level counts once.
                        if (Tick) begin
                            if (delay_cnt == DLY_LAST) begin
                                state        <= S_RUN;
                                delay_cnt    <= '0;
                                X_Coin_OO_L  <= X_PARK;
                                X_Coin_OO_R  <= XR_PARK;
                                Y_Coin_00    <= spawn_y;
                                Coin_Visible <= 1'b1;
                            end else begin
                                delay_cnt <= delay_cnt + DW'(1);
                            end
                        end
                    end
                    default: state <= S_INIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_coin_spawner.sv
// tb_coin_spawner: scenario tasks plus randomized traffic for coin_spawner,
// checked against a behavioural game model kept in the bench.
// Honours COIN_SPEEDUP_EN when the design is built with it.
module tb_coin_spawner;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic       Start = 1'b0;
    logic       Ack = 1'b0;
    logic       Tick = 1'b0;
    logic       get_Zero = 1'b0;
    logic [9:0] X_Coin_OO_L, X_Coin_OO_R, Y_Coin_00;
    logic       Coin_Visible, Collect_Pulse;
    logic [7:0] Coin_Count;

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc  = 0;

    coin_spawner dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .Tick(Tick),
        .get_Zero(get_Zero), .X_Coin_OO_L(X_Coin_OO_L), .X_Coin_OO_R(X_Coin_OO_R),
        .Y_Coin_00(Y_Coin_00), .Coin_Visible(Coin_Visible),
        .Collect_Pulse(Collect_Pulse), .Coin_Count(Coin_Count)
    );

    always #5 Clk = ~Clk;

    // ---------------- game model (plain integers, game rules) ----------------
    int       m_mode;      // 0 waiting to start, 1 coin in play, 2 coin away
    int       m_x, m_y, m_vis, m_pulse, m_cnt, m_wait, m_spd;
    bit [7:0] m_lfsr;

    function automatic int base_speed(input int coins);
`ifdef COIN_SPEEDUP_EN
        return 2 + (((coins / 8) > 3) ? 3 : (coins / 8));
`else
        return 2 + 0 * coins;
`endif
    endfunction

    function automatic logic [39:0] exp_vec();
        return {10'(m_x), 10'(m_x + 20), 10'(m_y), 1'(m_vis), 1'(m_pulse), 8'(m_cnt)};
    endfunction

    logic [39:0] dut_v;
    assign dut_v = {X_Coin_OO_L, X_Coin_OO_R, Y_Coin_00, Coin_Visible, Collect_Pulse, Coin_Count};

    task automatic model_edge();
        bit [7:0] cur;
        if (!reset) begin
            m_mode = 0; m_x = 640; m_y = 100; m_vis = 0; m_pulse = 0; m_cnt = 0;
            m_wait = 0; m_spd = 2; m_lfsr = 8'hA5;
            return;
        end
        cur = m_lfsr;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        m_pulse = 0;
        if (Ack) begin
            m_mode = 0; m_x = 640; m_y = 100; m_vis = 0; m_wait = 0;
        end else if (m_mode == 0) begin
            if (Start) begin
                m_mode = 1; m_cnt = 0; m_spd = 2; m_x = 640; m_y = 100 + cur; m_vis = 1;
            end
        end else if (m_mode == 1) begin
            if (get_Zero) begin
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_spd = base_speed(m_cnt);
                m_pulse = 1; m_x = 640; m_vis = 0; m_mode = 2; m_wait = 0;
            end else if (Tick) begin
                if (m_x >= m_spd)   m_x = m_x - m_spd;
                else if (m_x > 0)   m_x = 0;
                else begin m_x = 640; m_vis = 0; m_mode = 2; m_wait = 0; end
            end
        end else begin
            if (Tick) begin
                m_wait++;
                if (m_wait == 60) begin
                    m_wait = 0; m_x = 640; m_y = 100 + cur; m_vis = 1; m_mode = 1;
                end
            end
        end
    endtask

    // One clock: model follows the edge, outputs are then sampled 1ns later.
    task automatic cyc();
        @(posedge Clk);
        model_edge();
        #1;
        ncyc++;
    endtask

    // Tick every cycle until the coin is back in play (bounded).
    task automatic respawn();
        int guard = 0;
        Tick = 1'b1;
        while (m_mode != 1 && guard < 200) begin
            cyc(); guard++;
            n_cmp++;
            if (dut_v !== exp_vec()) begin
                n_bad++;
                $display("FAIL respawn cyc=%0d got=%h want=%h", ncyc, dut_v, exp_vec());
            end
        end
        Tick = 1'b0;
        n_cmp++;
        if (m_mode != 1) begin
            n_bad++;
            $display("FAIL respawn_timeout cyc=%0d got_vis=%0d want_vis=1", ncyc, Coin_Visible);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; Start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if (dut_v !== {10'd640, 10'd660, 10'd100, 1'b0, 1'b0, 8'd0}) begin
                n_bad++;
                $display("FAIL reset_vals cyc=%0d got=%h want=%h", ncyc, dut_v, exp_vec());
            end
        end
        reset = 1'b1; Start = 1'b0;
        cyc();
        n_cmp++;
        if (dut_v !== exp_vec() || Coin_Visible !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle got=%h want=%h", dut_v, exp_vec());
        end
    endtask

    task automatic test_start_move();
        bit [7:0] lf_load;
        int ticks = 0;
        lf_load = m_lfsr;
        Start = 1'b1; cyc(); Start = 1'b0;
        n_cmp++;
        if (Coin_Visible !== 1'b1 || X_Coin_OO_L !== 10'd640 || Y_Coin_00 !== 10'(100 + lf_load)) begin
            n_bad++;
            $display("FAIL start_load got vis=%0d x=%0d y=%0d want vis=1 x=640 y=%0d",
                     Coin_Visible, X_Coin_OO_L, Y_Coin_00, 100 + lf_load);
        end
        while (ticks < 10) begin
            Tick = ($urandom_range(0, 2) != 0);
            if (Tick) ticks++;
            cyc();
            n_cmp++;
            if (dut_v !== exp_vec()) begin
                n_bad++;
                $display("FAIL move cyc=%0d got=%h want=%h", ncyc, dut_v, exp_vec());
            end
        end
        Tick = 1'b0;
        n_cmp++;
        if (X_Coin_OO_L !== 10'd620 || X_Coin_OO_R !== 10'd640 || Coin_Visible !== 1'b1 ||
            Y_Coin_00 < 10'd100 || Y_Coin_00 > 10'd355) begin
            n_bad++;
            $display("FAIL after_10_ticks got x=%0d xr=%0d y=%0d want x=620 xr=640 y=100..355",
                     X_Coin_OO_L, X_Coin_OO_R, Y_Coin_00);
        end
    endtask

    task automatic test_hit_hold();
        int pulses = 0;
        get_Zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Tick = 1'($urandom_range(0, 1));
            cyc();
            if (Collect_Pulse === 1'b1) pulses++;
            n_cmp++;
            if (dut_v !== exp_vec()) begin
                n_bad++;
                $display("FAIL hit_hold cyc=%0d got=%h want=%h", ncyc, dut_v, exp_vec());
            end
        end
        get_Zero = 1'b0; Tick = 1'b0;
        n_cmp++;
        if (pulses != 1 || Coin_Count !== 8'd1 || Coin_Visible !== 1'b0 || X_Coin_OO_L !== 10'd640) begin
            n_bad++;
            $display("FAIL hit_once got pulses=%0d cnt=%0d x=%0d want pulses=1 cnt=1 x=640",
                     pulses, Coin_Count, X_Coin_OO_L);
        end
    endtask

    task automatic test_offscreen();
        int ticks = 0;
        bit [7:0] lf_load;
        respawn();
        while (ticks < 320) begin
            Tick = ($urandom_range(0, 3) != 0);
            if (Tick) ticks++;
            cyc();
            n_cmp++;
            if (dut_v !== exp_vec()) begin
                n_bad++;
                $display("FAIL scroll cyc=%0d got=%h want=%h", ncyc, dut_v, exp_vec());
            end
        end
        n_cmp++;
        if (X_Coin_OO_L !== 10'd0 || X_Coin_OO_R !== 10'd20 || Coin_Visible !== 1'b1) begin
            n_bad++;
            $display("FAIL at_left_edge got x=%0d vis=%0d want x=0 vis=1", X_Coin_OO_L, Coin_Visible);
        end
        Tick = 1'b1; cyc();
        n_cmp++;
        if (Coin_Visible !== 1'b0 || X_Coin_OO_L !== 10'd640 || Coin_Count !== 8'd1 || Collect_Pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL offscreen got vis=%0d x=%0d cnt=%0d want vis=0 x=640 cnt=1",
                     Coin_Visible, X_Coin_OO_L, Coin_Count);
        end
        for (int i = 0; i < 59; i++) cyc();
        lf_load = m_lfsr;
        cyc(); Tick = 1'b0;
        n_cmp++;
        if (Coin_Visible !== 1'b1 || X_Coin_OO_L !== 10'd640 || Y_Coin_00 !== 10'(100 + lf_load)) begin
            n_bad++;
            $display("FAIL respawn_60 got vis=%0d x=%0d y=%0d want vis=1 x=640 y=%0d",
                     Coin_Visible, X_Coin_OO_L, Y_Coin_00, 100 + lf_load);
        end
    endtask

    task automatic test_saturate();
        Ack = 1'b1; cyc(); Ack = 1'b0;
        Start = 1'b1; cyc(); Start = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            get_Zero = 1'b1; cyc(); get_Zero = 1'b0;
            n_cmp++;
            if (Collect_Pulse !== 1'b1 || dut_v !== exp_vec()) begin
                n_bad++;
                $display("FAIL collect_%0d got=%h want=%h", k, dut_v, exp_vec());
            end
            cyc();
            n_cmp++;
            if (Collect_Pulse !== 1'b0) begin
                n_bad++;
                $display("FAIL pulse_width_%0d got=%0d want=0", k, Collect_Pulse);
            end
            respawn();
            if (k == 8) begin
                Tick = 1'b1; cyc(); Tick = 1'b0;
                n_cmp++;
`ifdef COIN_SPEEDUP_EN
                if (X_Coin_OO_L !== 10'd637) begin
`else
                if (X_Coin_OO_L !== 10'd638) begin
`endif
                    n_bad++;
                    $display("FAIL speed_after_8 got x=%0d want=%0d", X_Coin_OO_L, m_x);
                end
            end
        end
        n_cmp++;
        if (Coin_Count !== 8'd255) begin
            n_bad++;
            $display("FAIL saturate got=%0d want=255", Coin_Count);
        end
    endtask

    task automatic test_corners();
        int cnt0;
        // Hit and Tick together: counted, coin does not move, then parked.
        for (int i = 0; i < 3; i++) begin Tick = 1'b1; cyc(); end
        cnt0 = m_cnt;
        get_Zero = 1'b1; Tick = 1'b1; cyc(); get_Zero = 1'b0; Tick = 1'b0;
        n_cmp++;
        if (dut_v !== exp_vec() || X_Coin_OO_L !== 10'd640 || Collect_Pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL hit_and_tick got=%h want=%h", dut_v, exp_vec());
        end
        // Ack mid-RUN: back to INIT, count kept.
        Ack = 1'b1; cyc(); Ack = 1'b0;
        Start = 1'b1; cyc(); Start = 1'b0;
        get_Zero = 1'b1; cyc(); get_Zero = 1'b0;
        respawn();
        cnt0 = m_cnt;
        Tick = 1'b1; cyc(); cyc(); Tick = 1'b0;
        Ack = 1'b1; cyc(); Ack = 1'b0;
        n_cmp++;
        if (Coin_Visible !== 1'b0 || X_Coin_OO_L !== 10'd640 || Coin_Count !== 8'(cnt0) ||
            Collect_Pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_run got vis=%0d x=%0d cnt=%0d want vis=0 x=640 cnt=%0d",
                     Coin_Visible, X_Coin_OO_L, Coin_Count, cnt0);
        end
        cyc();
        n_cmp++;
        if (dut_v !== exp_vec() || Coin_Visible !== 1'b0) begin
            n_bad++;
            $display("FAIL init_hold got=%h want=%h", dut_v, exp_vec());
        end
        // Reset while the coin is away.
        Start = 1'b1; cyc(); Start = 1'b0;
        get_Zero = 1'b1; cyc(); get_Zero = 1'b0;
        Tick = 1'b1; cyc(); cyc(); Tick = 1'b0;
        reset = 1'b0; Tick = 1'b1; get_Zero = 1'b1; cyc();
        reset = 1'b1; Tick = 1'b0; get_Zero = 1'b0;
        n_cmp++;
        if (dut_v !== {10'd640, 10'd660, 10'd100, 1'b0, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_in_gone got=%h want=%h", dut_v, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 799) != 0);
            Ack      = ($urandom_range(0, 99) == 0);
            Start    = ($urandom_range(0, 3) == 0);
            Tick     = ($urandom_range(0, 1) == 0);
            get_Zero = ($urandom_range(0, 5) == 0);
            cyc();
            n_cmp++;
            if (dut_v !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", ncyc, dut_v, exp_vec());
            end
        end
        reset = 1'b1; Ack = 1'b0; Start = 1'b0; Tick = 1'b0; get_Zero = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_start_move();
        test_hit_hold();
        test_offscreen();
        test_saturate();
        test_corners();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
